// File: rtl/batt_mon_pkg.sv
// Shared types and constants for the battery-voltage supervisor.
package batt_mon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StEval
  } state_t;

  localparam int unsigned TMR_W_FAST = 10;
  localparam int unsigned TMR_W_SLOW = 22;

  localparam logic [11:0] TO_TERM = 12'hFFF;

  function automatic int unsigned tmr_width(input bit fast);
    return fast ? TMR_W_FAST : TMR_W_SLOW;
  endfunction

endpackage

// File: rtl/batt_monitor_if.sv
// A2D handshake plus alarm/status outputs of the battery supervisor.
interface batt_monitor_if;

  logic        strt_cnv;
  logic        cnv_cmplt;
  logic [11:0] batt_res;
  logic        batt_low;
  logic        batt_vld;
  logic        cnv_err;

  modport master (
    output strt_cnv,
    output batt_low,
    output batt_vld,
    output cnv_err,
    input  cnv_cmplt,
    input  batt_res
  );

  modport slave (
    input  strt_cnv,
    input  batt_low,
    input  batt_vld,
    input  cnv_err,
    output cnv_cmplt,
    output batt_res
  );

endinterface

// File: rtl/batt_hyst.sv
// Threshold hysteresis with consecutive-sample debounce driving the registered batt_low alarm.
module batt_hyst #(
  parameter logic [11:0] LOW_THRESH  = 12'hA98,
  parameter logic [11:0] HIGH_THRESH = 12'hAC0,
  parameter int unsigned DEB_CNT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_eval,
  input  logic [11:0] i_sample,
  output logic        o_batt_low
);

  localparam logic [2:0] DEB_LAST = 3'(DEB_CNT - 1);

  logic       w_qual;
  logic [2:0] r_cnt;
  logic       r_low;

  // A sample qualifies only if it argues for leaving the current level.
  assign w_qual = r_low ? (i_sample >= HIGH_THRESH) : (i_sample < LOW_THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 3'd0;
      r_low <= 1'b0;
    end else if (i_eval) begin
      if (!w_qual) begin
        r_cnt <= 3'd0;
      end else if (r_cnt == DEB_LAST) begin
        r_low <= ~r_low;
        r_cnt <= 3'd0;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign o_batt_low = r_low;

endmodule

// File: rtl/batt_monitor.sv
// Periodic battery supervisor: interval timer, A2D request/timeout FSM, and hysteresis alarm.
module batt_monitor #(
  parameter bit          FAST_SIM    = 1'b1,
  parameter logic [11:0] LOW_THRESH  = 12'hA98,
  parameter logic [11:0] HIGH_THRESH = 12'hAC0,
  parameter int unsigned DEB_CNT     = 4
) (
  input logic            clk,
  input logic            rst,
  batt_monitor_if.master bus
);

  import batt_mon_pkg::*;

  localparam int unsigned      TMR_W    = tmr_width(FAST_SIM);
  localparam logic [TMR_W-1:0] TMR_TERM = '1;

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [11:0]      r_to;
  logic [11:0]      r_sample;
  logic             r_strt;
  logic             r_err;
  logic             r_vld;
  logic             w_eval;
  logic             w_batt_low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_tmr    <= '0;
      r_to     <= 12'd0;
      r_sample <= 12'd0;
      r_strt   <= 1'b0;
      r_err    <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      r_strt <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (r_tmr == TMR_TERM) begin
            r_state <= StConv;
            r_strt  <= 1'b1;
            r_tmr   <= '0;
            // Counts CONV cycles including the current one, so 4095 marks the timeout cycle.
            r_to    <= 12'd1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        StConv: begin
          if (bus.cnv_cmplt) begin
            r_sample <= bus.batt_res;
            r_to     <= 12'd0;
            r_state  <= StEval;
          end else if (r_to == TO_TERM) begin
            r_err   <= 1'b1;
            r_to    <= 12'd0;
            r_tmr   <= '0;
            r_state <= StIdle;
          end else begin
            r_to <= r_to + 12'd1;
          end
        end
        StEval: begin
          r_vld   <= 1'b1;
          r_tmr   <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_eval = (r_state == StEval);

  batt_hyst #(
    .LOW_THRESH (LOW_THRESH),
    .HIGH_THRESH(HIGH_THRESH),
    .DEB_CNT    (DEB_CNT)
  ) u_hyst (
    .clk       (clk),
    .rst       (rst),
    .i_eval    (w_eval),
    .i_sample  (r_sample),
    .o_batt_low(w_batt_low)
  );

  assign bus.strt_cnv = r_strt;
  assign bus.batt_low = w_batt_low;
  assign bus.batt_vld = r_vld;
  assign bus.cnv_err  = r_err;

endmodule
